// File: rtl/dircc_st_if.sv
// Avalon-ST packet stream bundle shared by the dircc input buffer and the router ports.
// master drives the payload and framing; slave returns ready (readyLatency 0).
interface dircc_st_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int EMPTY_WIDTH = 2
);
  logic [DATA_WIDTH-1:0]  data;
  logic                   valid;
  logic                   ready;
  logic                   startofpacket;
  logic                   endofpacket;
  logic [EMPTY_WIDTH-1:0] empty;

  modport master (
    output data, valid, startofpacket, endofpacket, empty,
    input  ready
  );

  modport slave (
    input  data, valid, startofpacket, endofpacket, empty,
    output ready
  );
endinterface

// File: rtl/dircc_input_buffer.sv
// Per-direction packet FIFO in front of a dircc_routing input port.
// A packet is only offered downstream once its EOP word is stored, unless it cannot fit.
module dircc_input_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int EMPTY_WIDTH = 2,
  parameter int DEPTH       = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int CUT_THROUGH = 0
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  dircc_st_if.slave             sink,
  dircc_st_if.master            source,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic [ADDR_WIDTH:0]   packet_count
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic                   sop;
    logic                   eop;
    logic [EMPTY_WIDTH-1:0] empty;
  } entry_t;

  typedef enum logic {
    GATE,
    FORWARD
  } state_t;

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  entry_t                mem [DEPTH];
  entry_t                head;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   pkt_count;
  state_t                state;
  state_t                state_next;
  logic                  valid;
  logic                  wr_en;
  logic                  rd_en;
  logic                  wr_eop;
  logic                  rd_eop;

  // Show-ahead: the head entry drives the source side combinationally.
  assign head                 = mem[rd_ptr];
  assign source.data          = head.data;
  assign source.startofpacket = head.sop;
  assign source.endofpacket   = head.eop;
  assign source.empty         = head.empty;
  assign source.valid         = valid;

  assign sink.ready = (count != FULL_COUNT);
  assign wr_en      = sink.valid & sink.ready;
  assign rd_en      = valid & source.ready;
  assign wr_eop     = wr_en & sink.endofpacket;
  assign rd_eop     = rd_en & head.eop;

  assign fill_level   = count;
  assign packet_count = pkt_count;

  // NOTE: the storage array is deliberately not reset; count decides which entries are meaningful.
  always_ff @(posedge clk_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= '{data:  sink.data,
                       sop:   sink.startofpacket,
                       eop:   sink.endofpacket,
                       empty: sink.empty};
    end
  end

  // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkt_count <= '0;
      state     <= GATE;
    end else begin
      state <= state_next;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;

      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case ({wr_eop, rd_eop})
        2'b10:   pkt_count <= pkt_count + 1'b1;
        2'b01:   pkt_count <= pkt_count - 1'b1;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  // A full FIFO with no complete packet is released anyway so oversize packets cannot deadlock the link.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    valid      = 1'b0;
    case (state)
      GATE: begin
        valid = (count != '0) && ((pkt_count != '0) || (count == FULL_COUNT));
        if (valid && source.ready && !head.eop) state_next = FORWARD;
      end
      FORWARD: begin
        valid = (count != '0);
        if (valid && source.ready && head.eop) state_next = GATE;
      end
      default: state_next = GATE;
    endcase
    if (CUT_THROUGH != 0) valid = (count != '0);
  end

endmodule

// File: tb/tb_dircc_input_buffer.sv
// Directed self-checking bench for dircc_input_buffer (DEPTH=16, store-and-forward mode).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_dircc_input_buffer;

  localparam int DATA_WIDTH  = 32;
  localparam int EMPTY_WIDTH = 2;
  localparam int DEPTH       = 16;
  localparam int ADDR_WIDTH  = 4;

  logic                clk_clk;
  logic                reset_reset_n;
  logic [ADDR_WIDTH:0] fill_level;
  logic [ADDR_WIDTH:0] packet_count;

  int checks = 0;
  int errors = 0;

  dircc_st_if #(.DATA_WIDTH(DATA_WIDTH), .EMPTY_WIDTH(EMPTY_WIDTH)) sink ();
  dircc_st_if #(.DATA_WIDTH(DATA_WIDTH), .EMPTY_WIDTH(EMPTY_WIDTH)) source ();

  dircc_input_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .EMPTY_WIDTH(EMPTY_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CUT_THROUGH(0)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .sink         (sink),
    .source       (source),
    .fill_level   (fill_level),
    .packet_count (packet_count)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] data, input logic sop, input logic eop,
                       input logic [1:0] empty);
    sink.valid         = 1'b1;
    sink.data          = data;
    sink.startofpacket = sop;
    sink.endofpacket   = eop;
    sink.empty         = empty;
  endtask

  task automatic idle();
    sink.valid         = 1'b0;
    sink.startofpacket = 1'b0;
    sink.endofpacket   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] got_data [$];
    logic        got_eop  [$];
    bit          seen_valid;
    int          wr_idx;

    reset_reset_n = 1'b0;
    source.ready  = 1'b0;
    sink.data     = '0;
    sink.empty    = '0;
    idle();
    tick();
    tick();

    // Reset state
    check("rst_in_ready", 64'(sink.ready), 64'd1);
    check("rst_out_valid", 64'(source.valid), 64'd0);
    check("rst_fill", 64'(fill_level), 64'd0);
    check("rst_pkt", 64'(packet_count), 64'd0);
    reset_reset_n = 1'b1;
    tick();

    // Single-word packet
    drive(32'hDEADBEEF, 1'b1, 1'b1, 2'd2);
    tick();
    idle();
    check("single_valid", 64'(source.valid), 64'd1);
    check("single_data", 64'(source.data), 64'hDEADBEEF);
    check("single_empty", 64'(source.empty), 64'd2);
    check("single_pkt", 64'(packet_count), 64'd1);
    source.ready = 1'b1;
    tick();
    check("single_fill_after", 64'(fill_level), 64'd0);
    check("single_pkt_after", 64'(packet_count), 64'd0);
    check("single_valid_after", 64'(source.valid), 64'd0);

    // Gating: 4-word packet written every other cycle, ready held high
    for (int i = 1; i <= 4; i++) begin
      drive(32'(i), i == 1, i == 4, 2'd0);
      tick();
      idle();
      if (i < 4) begin
        check("gate_hold_a", 64'(source.valid), 64'd0);
        tick();
        check("gate_hold_b", 64'(source.valid), 64'd0);
      end
    end
    for (int j = 1; j <= 4; j++) begin
      check("gate_valid", 64'(source.valid), 64'd1);
      check("gate_data", 64'(source.data), 64'(j));
      check("gate_sop", 64'(source.startofpacket), 64'(j == 1));
      check("gate_eop", 64'(source.endofpacket), 64'(j == 4));
      tick();
    end
    check("gate_drained", 64'(fill_level), 64'd0);
    check("gate_valid_end", 64'(source.valid), 64'd0);

    // Full / backpressure: two 8-word packets fill the FIFO
    source.ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(32'h100 + 32'(i), (i % 8) == 0, (i % 8) == 7, 2'd1);
      tick();
    end
    idle();
    check("full_in_ready", 64'(sink.ready), 64'd0);
    check("full_fill", 64'(fill_level), 64'd16);
    check("full_pkt", 64'(packet_count), 64'd2);
    check("full_head", 64'(source.data), 64'h100);
    drive(32'h0BAD, 1'b1, 1'b1, 2'd0);
    source.ready = 1'b1;
    tick();
    idle();
    source.ready = 1'b0;
    check("bp_fill", 64'(fill_level), 64'd15);
    check("bp_in_ready", 64'(sink.ready), 64'd1);
    check("bp_head", 64'(source.data), 64'h101);
    source.ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check("bp_drain_data", 64'(source.data), 64'h100 + 64'(i));
      tick();
    end
    check("bp_drain_fill", 64'(fill_level), 64'd0);
    check("bp_drain_pkt", 64'(packet_count), 64'd0);

    // Oversize packet: 20 words through a 16-entry FIFO
    seen_valid = 1'b0;
    wr_idx     = 0;
    for (int cyc = 0; cyc < 200 && got_data.size() < 20; cyc++) begin
      if (wr_idx < 20) drive(32'h200 + 32'(wr_idx), wr_idx == 0, wr_idx == 19, 2'd0);
      else idle();
      if (source.valid && !seen_valid) begin
        seen_valid = 1'b1;
        check("over_release_fill", 64'(fill_level), 64'd16);
      end
      if (source.valid && source.ready) begin
        got_data.push_back(source.data);
        got_eop.push_back(source.endofpacket);
      end
      if (sink.valid && sink.ready) wr_idx++;
      tick();
    end
    idle();
    check("over_count", 64'(got_data.size()), 64'd20);
    for (int i = 0; i < got_data.size(); i++) begin
      check("over_data", 64'(got_data[i]), 64'h200 + 64'(i));
    end
    if (got_eop.size() == 20) check("over_eop", 64'(got_eop[19]), 64'd1);
    check("over_fill_end", 64'(fill_level), 64'd0);

    // Simultaneous read/write of single-word packets, wrapping the pointers
    source.ready = 1'b0;
    drive(32'h300, 1'b1, 1'b1, 2'd0);
    tick();
    source.ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      drive(32'h300 + 32'(i), 1'b1, 1'b1, 2'd0);
      check("stream_data", 64'(source.data), 64'h300 + 64'(i - 1));
      check("stream_fill", 64'(fill_level), 64'd1);
      check("stream_pkt", 64'(packet_count), 64'd1);
      tick();
    end
    idle();
    check("stream_last", 64'(source.data), 64'h314);
    tick();
    check("stream_fill_end", 64'(fill_level), 64'd0);

    // Reset in the middle of a packet
    source.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h400 + 32'(i), i == 0, 1'b0, 2'd0);
      tick();
    end
    idle();
    check("mid_fill_pre", 64'(fill_level), 64'd3);
    #2;
    reset_reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(source.valid), 64'd0);
    check("mid_rst_fill", 64'(fill_level), 64'd0);
    check("mid_rst_in_ready", 64'(sink.ready), 64'd1);
    tick();
    reset_reset_n = 1'b1;
    tick();
    source.ready = 1'b1;
    drive(32'h500, 1'b1, 1'b0, 2'd0);
    tick();
    drive(32'h501, 1'b0, 1'b1, 2'd3);
    check("post_gate", 64'(source.valid), 64'd0);
    tick();
    idle();
    check("post_valid0", 64'(source.valid), 64'd1);
    check("post_data0", 64'(source.data), 64'h500);
    check("post_sop0", 64'(source.startofpacket), 64'd1);
    tick();
    check("post_data1", 64'(source.data), 64'h501);
    check("post_eop1", 64'(source.endofpacket), 64'd1);
    check("post_empty1", 64'(source.empty), 64'd3);
    tick();
    check("post_fill_end", 64'(fill_level), 64'd0);
    check("post_valid_end", 64'(source.valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
